axi_dma_mm2s_sequencer: RTL and testbench

- AXI4-Lite master that sequences the AXI DMA MM2S channel in simple (non-SG) mode through the DMA register file.
- Accepts one transfer command (source address, byte length) at a time and programs MM2S_DMACR, MM2S_SA and MM2S_LENGTH.
- Polls MM2S_DMASR until IOC or an error is reported, then clears IOC and reports completion.
- Sits between system control logic and the DMA s_axi_lite port; replaces ad-hoc register scripting.

---
 rtl/axi_dma_mm2s_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_dma_mm2s_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_mm2s_sequencer.sv
// axi_dma_mm2s_sequencer: AXI4-Lite master that programs the AXI DMA MM2S channel in simple
// mode for one command at a time, then polls DMASR until IOC, an error bit or a poll timeout.
module axi_dma_mm2s_sequencer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LEN_WIDTH  = 23,
    parameter int          POLL_GAP   = 16,
    parameter int          POLL_LIMIT = 4096
) (
    input  logic                 M_AXI_ACLK,
    input  logic                 M_AXI_ARESETN,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [31:0]          cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic                 busy,
    output logic [31:0]          M_AXI_AWADDR,
    output logic [2:0]           M_AXI_AWPROT,
    output logic                 M_AXI_AWVALID,
    input  logic                 M_AXI_AWREADY,
    output logic [31:0]          M_AXI_WDATA,
    output logic [3:0]           M_AXI_WSTRB,
    output logic                 M_AXI_WVALID,
    input  logic                 M_AXI_WREADY,
    input  logic [1:0]           M_AXI_BRESP,
    input  logic                 M_AXI_BVALID,
    output logic                 M_AXI_BREADY,
    output logic [31:0]          M_AXI_ARADDR,
    output logic [2:0]           M_AXI_ARPROT,
    output logic                 M_AXI_ARVALID,
    input  logic                 M_AXI_ARREADY,
    input  logic [31:0]          M_AXI_RDATA,
    input  logic [1:0]           M_AXI_RRESP,
    input  logic                 M_AXI_RVALID,
    output logic                 M_AXI_RREADY
);

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        IDLE, WR_CR, WR_SA, WR_LEN, GAP, RD_SR, CHECK, WR_CLR, DONE, ERR
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [31:0]           awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic [3:0]            sr_q, sr_d;
    logic                  rerr_q, rerr_d;
    logic [PW-1:0]         poll_q, poll_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  done_q, done_d, err_q, err_d;
    logic [2:0]            err_code_q, err_code_d, code;
    state_t                nxt_wr;
    logic                  unused_rdata;

    assign unused_rdata = ^{M_AXI_RDATA[31:13], M_AXI_RDATA[11:7], M_AXI_RDATA[3:0]};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        sr_d       = sr_q;
        rerr_d     = rerr_q;
        poll_d     = poll_q;
        gap_d      = gap_q;
        err_code_d = err_code_q;
        code       = 3'd0;
        nxt_wr     = (state_q == WR_CR) ? WR_SA : (state_q == WR_SA) ? WR_LEN :
                     (state_q == WR_LEN) ? GAP : DONE;
        unique case (state_q)
            IDLE: if (cmd_valid) begin
                addr_d  = cmd_addr;
                len_d   = cmd_len;
                poll_d  = '0;
                state_d = (cmd_len == '0) ? ERR : WR_CR;
                code    = 3'd1;
            end
            WR_CR, WR_SA, WR_LEN, WR_CLR: begin
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (bready_q && M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    state_d  = (M_AXI_BRESP != 2'b00) ? ERR : nxt_wr;
                    code     = 3'd2;
                end else if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                end
            end
            GAP: begin
                gap_d   = gap_q + 1'b1;
                state_d = (gap_q == GAP_LAST) ? RD_SR : GAP;
            end
            RD_SR: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    poll_d    = poll_q + 1'b1;
                end
                if (rready_q && M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    sr_d     = {M_AXI_RDATA[12], M_AXI_RDATA[6:4]};
                    rerr_d   = M_AXI_RRESP != 2'b00;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                state_d = (rerr_q || |sr_q[2:0]) ? ERR : sr_q[3] ? WR_CLR :
                          (poll_q == POLL_MAX) ? ERR : GAP;
                code    = rerr_q ? 3'd3 : |sr_q[2:0] ? 3'd4 : 3'd5;
            end
            default: state_d = IDLE;
        endcase
        // Each state entry launches its own single AXI transaction.
        if (state_d != state_q) begin
            gap_d = '0;
            if (state_d inside {WR_CR, WR_SA, WR_LEN, WR_CLR}) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                awaddr_d  = BASE_ADDR + ((state_d == WR_CR) ? 32'h00 : (state_d == WR_SA) ? 32'h18 :
                                         (state_d == WR_LEN) ? 32'h28 : 32'h04);
                wdata_d   = (state_d == WR_CR) ? 32'h0000_1001 : (state_d == WR_SA) ? addr_q :
                            (state_d == WR_LEN) ? {{(32-LEN_WIDTH){1'b0}}, len_q} : 32'h0000_1000;
            end
            if (state_d == RD_SR) begin
                arvalid_d = 1'b1;
                araddr_d  = BASE_ADDR + 32'h04;
            end
        end
        done_d = state_d == DONE;
        err_d  = state_d == ERR;
        if (state_d == ERR) err_code_d = code;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            sr_q       <= '0;
            rerr_q     <= 1'b0;
            poll_q     <= '0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            sr_q       <= sr_d;
            rerr_q     <= rerr_d;
            poll_q     <= poll_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign cmd_ready     = state_q == IDLE;
    assign busy          = state_q != IDLE;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_dma_mm2s_sequencer.sv
// tb_axi_dma_mm2s_sequencer: randomized AXI4-Lite slave plus a command-level reference model
// that predicts register writes, status reads and the final done/err outcome.
module tb_axi_dma_mm2s_sequencer;

    localparam logic [31:0] BASE = 32'h4040_0000;
    localparam int LW = 23;
    localparam int PG = 16;
    localparam int PL = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic done, err, busy;
    logic [2:0] err_code;
    logic [31:0] awaddr, wdata, araddr;
    logic [31:0] rdata = '0;
    logic [2:0] awprot, arprot;
    logic [3:0] wstrb;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0] bresp = '0, rresp = '0;

    axi_dma_mm2s_sequencer #(.BASE_ADDR(BASE), .LEN_WIDTH(LW), .POLL_GAP(PG), .POLL_LIMIT(PL)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .done(done), .err(err), .err_code(err_code), .busy(busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // scenario knobs
    int bfail = -1, rfail = -1;
    logic [31:0] sr_val [8];
    int aw_fix = -1, w_fix = -1, b_fix = -1, ar_fix = -1, r_fix = -1;

    // observations
    logic [63:0] wr_log [$];
    logic [63:0] exp_wr [$];
    int rd_cnt = 0, done_cnt = 0, err_cnt = 0, proto_bad = 0;
    logic [2:0] err_seen = '0;
    logic [2:0] last_code = '0;

    // slave state
    int widx = 0, ridx = 0, cyc = 0, last_evt = 0, exp_gap = 0;
    bit gap_armed = 0;
    bit aw_got = 0, w_got = 0, b_pend = 0, b_fire = 0, ar_got = 0, r_pend = 0, r_fire = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [31:0] aw_a = '0, w_d = '0, aw_first = '0, w_first = '0, ar_first = '0;

    function automatic int dly(input int fix);
        return (fix >= 0) ? fix : int'($urandom_range(0, 3));
    endfunction

    task automatic pick_dly();
        aw_dly = dly(aw_fix); w_dly = dly(w_fix); b_dly = dly(b_fix);
        ar_dly = dly(ar_fix); r_dly = dly(r_fix);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_got = 0; w_got = 0; b_pend = 0; b_fire = 0; ar_got = 0; r_pend = 0; r_fire = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; gap_armed = 0;
                continue;
            end
            if (done) done_cnt++;
            if (err) begin err_cnt++; err_seen = err_code; end
            if ((arvalid || rready) && (awvalid || wvalid || bready)) proto_bad++;
            if (b_fire) begin
                bvalid = 0; b_pend = 0; b_fire = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
                if (widx == 2) begin last_evt = cyc - 1; exp_gap = PG; gap_armed = 1; end
                widx++;
                aw_dly = dly(aw_fix); w_dly = dly(w_fix); b_dly = dly(b_fix);
            end
            if (r_fire) begin
                rvalid = 0; r_pend = 0; r_fire = 0; ar_got = 0; ar_cnt = 0;
                last_evt = cyc - 1; exp_gap = PG + 1; gap_armed = 1;
                ridx++;
                ar_dly = dly(ar_fix); r_dly = dly(r_fix);
            end
            if (bready && !(aw_got && w_got)) proto_bad++;
            if (rready && !ar_got) proto_bad++;
            if (awvalid && !aw_got) begin
                if (aw_cnt == 0) aw_first = awaddr; else if (awaddr !== aw_first) proto_bad++;
                awready = aw_cnt >= aw_dly; aw_cnt++;
            end else begin
                if (awvalid) proto_bad++;
                awready = 0;
            end
            if (awvalid && awready) begin aw_got = 1; aw_a = awaddr; end
            if (wvalid && !w_got) begin
                if (w_cnt == 0) w_first = wdata; else if (wdata !== w_first) proto_bad++;
                wready = w_cnt >= w_dly; w_cnt++;
            end else begin
                if (wvalid) proto_bad++;
                wready = 0;
            end
            if (wvalid && wready) begin w_got = 1; w_d = wdata; end
            if (aw_got && w_got && !b_pend) begin b_pend = 1; b_cnt = 0; wr_log.push_back({aw_a, w_d}); end
            if (b_pend) begin
                bvalid = b_cnt >= b_dly + 1; b_cnt++;
                bresp = (widx == bfail) ? 2'b10 : 2'b00;
                b_fire = bvalid && bready;
            end
            if (arvalid && !ar_got) begin
                if (ar_cnt == 0) begin
                    ar_first = araddr; rd_cnt++;
                    chk("araddr", araddr, BASE + 32'h4);
                    if (gap_armed) chk("poll_gap", cyc - last_evt - 1, exp_gap);
                    gap_armed = 0;
                end else if (araddr !== ar_first) proto_bad++;
                arready = ar_cnt >= ar_dly; ar_cnt++;
            end else begin
                if (arvalid) proto_bad++;
                arready = 0;
            end
            if (arvalid && arready) ar_got = 1;
            if (ar_got && !r_pend) begin r_pend = 1; r_cnt = 0; end
            if (r_pend) begin
                rvalid = r_cnt >= r_dly + 1; r_cnt++;
                rdata = sr_val[ridx & 7];
                rresp = (ridx == rfail) ? 2'b10 : 2'b00;
                r_fire = rvalid && rready;
            end
        end
    end

    // Command-level prediction: register writes in order, number of DMASR reads, outcome code.
    task automatic model(input logic [31:0] a, input logic [LW-1:0] l, output int code, output int nr);
        logic [31:0] wa [3];
        logic [31:0] wd [3];
        exp_wr.delete(); nr = 0; code = 0;
        if (l == '0) begin code = 1; return; end
        wa = '{BASE, BASE + 32'h18, BASE + 32'h28};
        wd = '{32'h0000_1001, a, 32'(l)};
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back({wa[i], wd[i]});
            if (bfail == i) begin code = 2; return; end
        end
        for (int k = 0; k < PL; k++) begin
            nr = k + 1;
            if (rfail == k) begin code = 3; return; end
            if (sr_val[k][6:4] != 3'b000) begin code = 4; return; end
            if (sr_val[k][12]) begin
                exp_wr.push_back({BASE + 32'h4, 32'h0000_1000});
                code = (bfail == 3) ? 2 : 0;
                return;
            end
        end
        code = 5;
    endtask

    task automatic scen(input int bf, input int rf, input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] s3);
        bfail = bf; rfail = rf;
        sr_val = '{s0, s1, s2, s3, 32'h0, 32'h0, 32'h0, 32'h0};
    endtask

    task automatic run(input logic [31:0] a, input logic [LW-1:0] l, input string nm);
        int code, nr, t, n;
        model(a, l, code, nr);
        wr_log.delete(); rd_cnt = 0; done_cnt = 0; err_cnt = 0; proto_bad = 0;
        widx = 0; ridx = 0; gap_armed = 0;
        pick_dly();
        @(negedge clk); #1;
        chk({nm, ":cmd_ready_idle"}, 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_addr = a; cmd_len = l;
        @(negedge clk); #1;
        cmd_valid = 0;
        chk({nm, ":aw_latency"}, 32'(awvalid), 32'(l != '0));
        chk({nm, ":cmd_ready_busy"}, 32'({cmd_ready, busy}), 1);
        t = 0;
        while (done_cnt == 0 && err_cnt == 0 && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        chk({nm, ":finished"}, 32'(t < 2000), 1);
        @(negedge clk); #1;
        chk({nm, ":idle_after"}, 32'({cmd_ready, busy, done, err}), 32'b1000);
        repeat (2) @(negedge clk);
        #1;
        chk({nm, ":done_cnt"}, done_cnt, (code == 0) ? 1 : 0);
        chk({nm, ":err_cnt"}, err_cnt, (code != 0) ? 1 : 0);
        if (code != 0) begin
            chk({nm, ":err_code"}, 32'(err_seen), code);
            last_code = 3'(code);
        end
        chk({nm, ":err_code_hold"}, 32'(err_code), 32'(last_code));
        chk({nm, ":n_writes"}, wr_log.size(), exp_wr.size());
        n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, ":wr_addr"}, wr_log[i][63:32], exp_wr[i][63:32]);
            chk({nm, ":wr_data"}, wr_log[i][31:0], exp_wr[i][31:0]);
        end
        chk({nm, ":n_reads"}, rd_cnt, nr);
        chk({nm, ":protocol"}, proto_bad, 0);
    endtask

    function automatic logic [31:0] rand_sr();
        logic [31:0] r;
        int s;
        r = $urandom;
        s = $urandom_range(0, 9);
        if (s <= 4) return r & ~32'h0000_1070;
        if (s <= 7) return (r & ~32'h0000_0070) | 32'h0000_1000;
        if (s == 8) return r | (32'h10 << $urandom_range(0, 2));
        return 32'h0;
    endfunction

    initial begin
        int t;
        logic [LW-1:0] l;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, done, err, busy}), 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("fixed_fields", 32'({awprot, arprot, wstrb}), 32'h00F);
        rst_n = 1;
        @(negedge clk); #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);

        aw_fix = 0; w_fix = 0; b_fix = 0; ar_fix = 0; r_fix = 0;
        scen(-1, -1, 32'h0, 32'h0, 32'h1000, 32'h0);
        run(32'h1000_0000, 23'h100, "basic");
        aw_fix = 5; w_fix = 0;
        run(32'h2000_0040, 23'h80, "aw_slow");
        aw_fix = -1; w_fix = -1; b_fix = -1; ar_fix = -1; r_fix = -1;
        run(32'h3000_0000, 23'h0, "zero_len");
        scen(1, -1, 32'h1000, 32'h0, 32'h0, 32'h0);
        run(32'h3000_1000, 23'h40, "bresp_sa");
        scen(-1, -1, 32'h20, 32'h0, 32'h0, 32'h0);
        run(32'h3000_2000, 23'h44, "dmasr_err");
        scen(-1, -1, 32'h0, 32'h0, 32'h0, 32'h0);
        run(32'h3000_3000, 23'h7F_FFFF, "timeout");
        scen(-1, 1, 32'h0, 32'h1000, 32'h0, 32'h0);
        run(32'h3000_4000, 23'h10, "rresp");
        scen(3, -1, 32'h2, 32'h1000, 32'h0, 32'h0);
        run(32'h3000_5000, 23'h20, "bresp_clr");

        scen(-1, -1, 32'h0, 32'h0, 32'h0, 32'h0);
        widx = 0; ridx = 0; gap_armed = 0; pick_dly();
        @(negedge clk); #1;
        cmd_valid = 1; cmd_addr = 32'h5000_0000; cmd_len = 23'h40;
        @(negedge clk); #1;
        cmd_valid = 0;
        t = 0;
        while (!arvalid && t < 300) begin
            @(negedge clk); #1;
            t++;
        end
        chk("rst_reach_rd_sr", 32'(arvalid), 1);
        #2 rst_n = 0;
        #1 chk("rst_async_valids", 32'({awvalid, wvalid, bready, arvalid, rready, done, err, busy}), 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1; done_cnt = 0; err_cnt = 0; last_code = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_no_completion", done_cnt + err_cnt, 0);
        chk("rst_err_code_clr", 32'(err_code), 0);
        scen(-1, -1, 32'h1, 32'h1000, 32'h0, 32'h0);
        run(32'h5000_0100, 23'h200, "after_rst");

        for (int i = 0; i < 25; i++) begin
            scen(($urandom_range(0, 5) < 4) ? -1 : int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                 rand_sr(), rand_sr(), rand_sr(), rand_sr());
            l = ($urandom_range(0, 9) == 0) ? '0 : LW'($urandom);
            run($urandom, l, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
